// File: rtl/mips_run_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : mips_run_ctrl
// Run/halt/burst-step controller for a MIPS core with debounced buttons and
// PC breakpoints.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module mips_run_ctrl #(
  parameter int PC_W       = 32,
  parameter int NUM_BP     = 2,
  parameter int DEB_CYCLES = 4,
  parameter int BURST_W    = 8,
  parameter int CNT_W      = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   change,
  input  logic                   step,
  input  logic [BURST_W-1:0]     burst_len,
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  output logic                   cpu_en,
  output logic [1:0]             mode,
  output logic [NUM_BP-1:0]      bp_hit,
  output logic [CNT_W-1:0]       instr_count
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  localparam int               DEB_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  state_t              state_q;
  logic [BURST_W-1:0]  burst_q;
  logic                skip_q;
  logic [NUM_BP-1:0]   bp_hit_q;
  logic [CNT_W-1:0]    count_q;

  logic [1:0]          raw_btn;
  logic [1:0]          btn_p;
  logic                chg_p;
  logic                stp_p;
  logic [NUM_BP-1:0]   bp_match;
  logic                bp_stop;
  logic                active;
  logic [BURST_W-1:0]  burst_ld;

  assign raw_btn = {step, change};

  // Two-flop synchroniser, then a level that only follows the synchronised
  // input once it has differed for DEB_CYCLES samples in a row.
  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic             meta_q;
    logic             sync_q;
    logic             lvl_q;
    logic             lvl_dly_q;
    logic [DEB_W-1:0] deb_q;

    always_ff @(posedge clock) begin
      if (!reset) begin
        meta_q    <= 1'b0;
        sync_q    <= 1'b0;
        lvl_q     <= 1'b0;
        lvl_dly_q <= 1'b0;
        deb_q     <= '0;
      end else begin
        meta_q    <= raw_btn[g];
        sync_q    <= meta_q;
        lvl_dly_q <= lvl_q;
        if (sync_q == lvl_q) begin
          deb_q <= '0;
        end else if (deb_q == DEB_LAST) begin
          lvl_q <= sync_q;
          deb_q <= '0;
        end else begin
          deb_q <= deb_q + DEB_W'(1);
        end
      end
    end

    assign btn_p[g] = lvl_q & ~lvl_dly_q;
  end

  assign chg_p = btn_p[0];
  assign stp_p = btn_p[1];

  always_comb begin
    bp_match = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      bp_match[i] = bp_en[i] && (pc == bp_addr[i*PC_W +: PC_W]);
    end
  end

  // Skip lets the first instruction after a resume run even if it sits on a breakpoint.
  assign bp_stop  = (|bp_match) && !skip_q;
  assign active   = (state_q == ST_RUN) || (state_q == ST_BURST);
  assign cpu_en   = active && !bp_stop;
  assign burst_ld = (burst_len == '0) ? BURST_W'(1) : burst_len;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_HALT;
      burst_q  <= '0;
      skip_q   <= 1'b0;
      bp_hit_q <= '0;
      count_q  <= '0;
    end else begin
      if (cpu_en) begin
        count_q <= count_q + CNT_W'(1);
        skip_q  <= 1'b0;
      end
      case (state_q)
        ST_HALT: begin
          if (chg_p) begin
            state_q  <= ST_RUN;
            skip_q   <= 1'b1;
            bp_hit_q <= '0;
          end else if (stp_p) begin
            state_q  <= ST_BURST;
            burst_q  <= burst_ld;
            skip_q   <= 1'b1;
            bp_hit_q <= '0;
          end
        end
        ST_RUN: begin
          if (bp_stop) begin
            bp_hit_q <= bp_hit_q | bp_match;
            state_q  <= ST_HALT;
          end else if (chg_p) begin
            state_q <= ST_HALT;
          end
        end
        ST_BURST: begin
          if (bp_stop) begin
            bp_hit_q <= bp_hit_q | bp_match;
            burst_q  <= '0;
            state_q  <= ST_HALT;
          end else if (chg_p) begin
            burst_q <= '0;
            state_q <= ST_HALT;
          end else if (cpu_en) begin
            burst_q <= burst_q - BURST_W'(1);
            if (burst_q == BURST_W'(1)) begin
              state_q <= ST_HALT;
            end
          end
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  assign mode        = state_q;
  assign bp_hit      = bp_hit_q;
  assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_run_ctrl.sv
`default_nettype none
// Scoreboard bench for mips_run_ctrl: directed button, burst, breakpoint and
// reset scenarios; expectations queued at stimulus time, popped by a monitor.
module tb_mips_run_ctrl;
  localparam int PC_W       = 32;
  localparam int NUM_BP     = 2;
  localparam int DEB_CYCLES = 4;
  localparam int BURST_W    = 8;
  localparam int CNT_W      = 32;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic                   change = 1'b0;
  logic                   step = 1'b0;
  logic [BURST_W-1:0]     burst_len = '0;
  logic [PC_W-1:0]        pc;
  logic [NUM_BP*PC_W-1:0] bp_addr = '0;
  logic [NUM_BP-1:0]      bp_en = '0;
  logic                   cpu_en;
  logic [1:0]             mode;
  logic [NUM_BP-1:0]      bp_hit;
  logic [CNT_W-1:0]       instr_count;

  logic pc_clr = 1'b1;
  logic probe_req = 1'b0;
  int   checks = 0;
  int   failures = 0;

  typedef struct packed {
    logic [7:0]  id;
    logic [1:0]  mode;
    logic        en;
    logic [31:0] cnt;
    logic [1:0]  hit;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] next_id = 8'd0;

  mips_run_ctrl #(
    .PC_W(PC_W), .NUM_BP(NUM_BP), .DEB_CYCLES(DEB_CYCLES),
    .BURST_W(BURST_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .change(change), .step(step),
    .burst_len(burst_len), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .cpu_en(cpu_en), .mode(mode), .bp_hit(bp_hit), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  // Core model: PC advances by one instruction per enabled cycle.
  always @(posedge clock) begin
    if (pc_clr) pc <= '0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  task automatic cmp(input logic [7:0] id, input string what,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL chk%0d.%s actual=%0h required=%0h", id, what, act, req);
    end
  endtask

  task automatic pop_check(input string src);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected actual_mode=%0d required=none", src, mode);
    end else begin
      e = exp_q.pop_front();
      cmp(e.id, "mode",  32'(mode),        32'(e.mode));
      cmp(e.id, "cpu_en", 32'(cpu_en),     32'(e.en));
      cmp(e.id, "count", 32'(instr_count), e.cnt);
      cmp(e.id, "bp_hit", 32'(bp_hit),     32'(e.hit));
    end
  endtask

  // Monitor: pops on every mode change the DUT presents and on probe strobes.
  initial begin
    logic [1:0] prev_mode;
    prev_mode = 2'b00;
    forever begin
      @(negedge clock);
      if (mode !== prev_mode) pop_check("mode_event");
      if (probe_req) pop_check("probe");
      prev_mode = mode;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] m, input logic en,
                      input logic [31:0] cnt, input logic [1:0] hit);
    exp_t e;
    e.id   = next_id;
    e.mode = m;
    e.en   = en;
    e.cnt  = cnt;
    e.hit  = hit;
    next_id++;
    exp_q.push_back(e);
  endtask

  task automatic probe(input logic [1:0] m, input logic en,
                       input logic [31:0] cnt, input logic [1:0] hit);
    push(m, en, cnt, hit);
    probe_req = 1'b1;
    @(negedge clock);
    #1;
    probe_req = 1'b0;
  endtask

  task automatic press(input logic c, input logic s, input int hold);
    change = c;
    step   = s;
    tick(hold);
    change = 1'b0;
    step   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    probe(2'd0, 1'b0, 32'd0, 2'b00);           // reset state
    reset = 1'b1;

    // Run then halt: 30 cycles between press starts -> 30 instructions
    push(2'd1, 1'b1, 32'd0, 2'b00);
    press(1'b1, 1'b0, 10);
    tick(5);
    probe(2'd1, 1'b1, 32'd8, 2'b00);
    tick(15);
    push(2'd0, 1'b0, 32'd30, 2'b00);
    press(1'b1, 1'b0, 10);
    tick(20);
    probe(2'd0, 1'b0, 32'd30, 2'b00);          // count frozen in HALT

    // Burst of 3, then burst_len 0 behaves as 1
    burst_len = 8'd3;
    push(2'd2, 1'b1, 32'd30, 2'b00);
    push(2'd0, 1'b0, 32'd33, 2'b00);
    press(1'b0, 1'b1, 10);
    tick(20);
    burst_len = 8'd0;
    push(2'd2, 1'b1, 32'd33, 2'b00);
    push(2'd0, 1'b0, 32'd34, 2'b00);
    press(1'b0, 1'b1, 10);
    tick(20);

    // Two-cycle glitch must not change anything
    press(1'b1, 1'b0, 2);
    tick(20);
    probe(2'd0, 1'b0, 32'd34, 2'b00);

    // Simultaneous change+step from HALT -> RUN, then halt again
    burst_len = 8'd5;
    push(2'd1, 1'b1, 32'd34, 2'b00);
    press(1'b1, 1'b1, 10);
    tick(20);
    push(2'd0, 1'b0, 32'd64, 2'b00);
    press(1'b1, 1'b0, 10);
    tick(20);

    // Breakpoint at 0x10 in slot 0; slot 1 holds the same address but is disabled
    bp_addr = {32'h0000_0010, 32'h0000_0010};
    bp_en   = 2'b01;
    pc_clr  = 1'b0;
    push(2'd1, 1'b1, 32'd64, 2'b00);
    press(1'b1, 1'b0, 10);
    tick(1);
    probe(2'd1, 1'b0, 32'd68, 2'b00);          // stalled at pc 0x10
    push(2'd0, 1'b0, 32'd68, 2'b01);
    tick(19);
    burst_len = 8'd1;
    push(2'd2, 1'b1, 32'd68, 2'b00);           // resume issues 0x10, hits cleared
    push(2'd0, 1'b0, 32'd69, 2'b00);
    press(1'b0, 1'b1, 10);
    tick(20);

    // Reset in the middle of an 8-instruction burst with 5 remaining
    bp_en     = 2'b00;
    pc_clr    = 1'b1;
    burst_len = 8'd8;
    push(2'd2, 1'b1, 32'd69, 2'b00);
    press(1'b0, 1'b1, 10);
    probe(2'd2, 1'b1, 32'd72, 2'b00);
    reset = 1'b0;
    push(2'd0, 1'b0, 32'd0, 2'b00);
    tick(3);
    reset = 1'b1;
    probe(2'd0, 1'b0, 32'd0, 2'b00);
    tick(20);

    for (int k = 0; k < 50 && exp_q.size() > 0; k++) tick(1);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL chk%0d.missing actual=none required_mode=%0d", e.id, e.mode);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
